// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg: shared state encoding and wait-counter width for load_store_unit.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_t;

  // Wide enough for WAIT_CYCLES up to 15.
  localparam int WAIT_CNT_W = 4;

endpackage

`default_nettype wire

// File: rtl/lsu_load_align.sv
// ---------------------------------------------------------------------------
// lsu_load_align: selects word or low byte of memory read data and extends it.
// Build option: LSU_LB_SIGN_EXT_EN (sign-extend byte loads). Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lsu_load_align #(
  parameter int DATA_W = 32
) (
  input  logic              byte_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [DATA_W-1:0] data_o
);

  always_comb begin
    data_o = rdata_i;
    if (byte_i) begin
`ifdef LSU_LB_SIGN_EXT_EN
      data_o = {{(DATA_W-8){rdata_i[7]}}, rdata_i[7:0]};
`else
      data_o = {{(DATA_W-8){1'b0}}, rdata_i[7:0]};
`endif
    end
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit: registered lw/sw/lb/sb controller for a byte-addressed memory.
// Build option: LSU_LB_SIGN_EXT_EN (sign-extend byte loads). Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 32,
  parameter int MEM_BYTES   = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_memRead,
  output logic              mem_memWrite,
  output logic              mem_byteOperations,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam logic [ADDR_W:0]     MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES - 1);

  lsu_state_t              state_q;
  logic [WAIT_CNT_W-1:0]   cnt_q;
  logic                    req_ready_q;
  logic                    write_q;
  logic                    byte_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [DATA_W-1:0]       wdata_q;
  logic                    rd_q;
  logic                    wr_q;
  logic                    byteop_q;
  logic                    resp_valid_q;
  logic                    resp_err_q;
  logic [DATA_W-1:0]       resp_rdata_q;

  logic [ADDR_W:0]         addr_ext;
  logic                    req_err_d;
  logic [DATA_W-1:0]       load_data_d;

  // One extra bit so addr+3 near the top of the address space cannot wrap.
  assign addr_ext  = {1'b0, req_addr};
  assign req_err_d = (addr_ext >= MEM_LIMIT)
                   | (~req_byte & (req_addr[1:0] != 2'b00))
                   | (~req_byte & ((addr_ext + (ADDR_W+1)'(3)) >= MEM_LIMIT));

  lsu_load_align #(.DATA_W(DATA_W)) u_align (
    .byte_i  (byte_q),
    .rdata_i (mem_read_data),
    .data_o  (load_data_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b0;
      write_q      <= 1'b0;
      byte_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      byteop_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            write_q     <= req_write;
            byte_q      <= req_byte;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            if (req_err_d) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else begin
              state_q  <= ACCESS;
              cnt_q    <= WAIT_LOAD;
              rd_q     <= ~req_write;
              wr_q     <= req_write;
              byteop_q <= req_byte;
            end
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            byteop_q     <= 1'b0;
            resp_rdata_q <= write_q ? '0 : load_data_d;
            resp_err_q   <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready          = req_ready_q;
  assign resp_valid         = resp_valid_q;
  assign resp_err           = resp_err_q;
  assign resp_rdata         = resp_rdata_q;
  assign mem_address        = addr_q;
  assign mem_write_data     = wdata_q;
  assign mem_memRead        = rd_q;
  assign mem_memWrite       = wr_q;
  assign mem_byteOperations = byteop_q;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit: scoreboard bench for load_store_unit with a byte memory model.
// Build option: LSU_LB_SIGN_EXT_EN selects sign-extended byte-load expectations.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_load_store_unit;

  localparam int WC = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic        req_byte = 1'b0;
  logic [17:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [17:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_memRead;
  logic        mem_memWrite;
  logic        mem_byteOperations;
  logic [31:0] mem_read_data;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  logic [7:0] mem [0:255];
  logic [7:0] ma;

  always #5 clk = ~clk;

  load_store_unit #(
    .ADDR_W(18), .DATA_W(32), .MEM_BYTES(256), .WAIT_CYCLES(WC)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_memRead(mem_memRead), .mem_memWrite(mem_memWrite),
    .mem_byteOperations(mem_byteOperations), .mem_read_data(mem_read_data)
  );

  // Little-endian byte memory: combinational read, write on the rising edge.
  always_comb begin
    ma = mem_address[7:0];
    mem_read_data = '0;
    if (mem_byteOperations) mem_read_data = {24'h0, mem[ma]};
    else mem_read_data = {mem[ma+8'd3], mem[ma+8'd2], mem[ma+8'd1], mem[ma]};
  end

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (mem_memWrite) begin
      mem[ma] <= mem_write_data[7:0];
      if (!mem_byteOperations) begin
        mem[ma+8'd1] <= mem_write_data[15:8];
        mem[ma+8'd2] <= mem_write_data[23:16];
        mem[ma+8'd3] <= mem_write_data[31:24];
      end
    end
  end

  function automatic logic [31:0] lb_ext(input logic [7:0] b);
`ifdef LSU_LB_SIGN_EXT_EN
    return {{24{b[7]}}, b};
`else
    return {24'h0, b};
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, obs, exp);
    end
  endtask

  // Drive one request (called at a negedge); returns at the negedge after acceptance.
  task automatic issue(input logic wr, input logic by, input logic [17:0] addr,
                       input logic [31:0] wd, input logic [31:0] er, input logic ee);
    int n = 0;
    req_write = wr; req_byte = by; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("accept_timeout", 32'd0, 32'd1);
    sb_q.push_back('{rdata: er, err: ee});
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Wait for the response, count strobe cycles, compare, optionally stall, then handshake.
  task automatic collect(input string tag, input int hold, input int exp_rd, input int exp_wr);
    int n = 0, rd = 0, wrc = 0;
    exp_t e;
    while (!resp_valid && n < 50) begin
      if (mem_memRead) rd++;
      if (mem_memWrite) wrc++;
      if (mem_memRead && mem_memWrite) check({tag, "_both_strobes"}, 32'd1, 32'd0);
      @(negedge clk);
      n++;
    end
    if (!resp_valid) begin
      check({tag, "_resp_timeout"}, 32'd0, 32'd1);
      return;
    end
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    check({tag, "_rdata"}, resp_rdata, e.rdata);
    check({tag, "_err"}, {31'd0, resp_err}, {31'd0, e.err});
    check({tag, "_rd_cycles"}, 32'(rd), 32'(exp_rd));
    check({tag, "_wr_cycles"}, 32'(wrc), 32'(exp_wr));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, {31'd0, resp_valid}, 32'd1);
      check({tag, "_hold_rdata"}, resp_rdata, e.rdata);
      check({tag, "_hold_ready"}, {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, "_valid_drop"}, {31'd0, resp_valid}, 32'd0);
    check({tag, "_ready_rise"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_strobes", {29'd0, mem_memRead, mem_memWrite, mem_byteOperations}, 32'd0);
    check("rst_addr", {14'd0, mem_address}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);

    issue(1'b1, 1'b0, 18'h010, 32'hDEADBEEF, 32'h0, 1'b0);
    collect("sw10", 0, 0, WC);
    issue(1'b0, 1'b0, 18'h010, 32'h0, 32'hDEADBEEF, 1'b0);
    collect("lw10", 0, WC, 0);

    issue(1'b1, 1'b1, 18'h021, 32'h000000F0, 32'h0, 1'b0);
    collect("sb21", 0, 0, WC);
    issue(1'b0, 1'b1, 18'h021, 32'h0, lb_ext(8'hF0), 1'b0);
    collect("lb21", 0, WC, 0);

    issue(1'b1, 1'b0, 18'h030, 32'h11223344, 32'h0, 1'b0);
    collect("sw30", 0, 0, WC);
    issue(1'b0, 1'b1, 18'h032, 32'h0, lb_ext(8'h22), 1'b0);
    collect("lb32", 0, WC, 0);

    issue(1'b0, 1'b0, 18'h013, 32'h0, 32'h0, 1'b1);
    collect("lw13_mis", 0, 0, 0);
    issue(1'b0, 1'b0, 18'h100, 32'h0, 32'h0, 1'b1);
    collect("lw100_oor", 0, 0, 0);
    issue(1'b1, 1'b1, 18'h100, 32'hFFFFFFFF, 32'h0, 1'b1);
    collect("sb100_oor", 0, 0, 0);
    issue(1'b0, 1'b0, 18'h0FE, 32'h0, 32'h0, 1'b1);
    collect("lwFE_mis", 0, 0, 0);

    issue(1'b1, 1'b0, 18'h0FC, 32'hCAFEF00D, 32'h0, 1'b0);
    collect("swFC", 0, 0, WC);
    issue(1'b0, 1'b0, 18'h0FC, 32'h0, 32'hCAFEF00D, 1'b0);
    collect("lwFC", 0, WC, 0);
    issue(1'b0, 1'b1, 18'h0FF, 32'h0, lb_ext(8'hCA), 1'b0);
    collect("lbFF", 0, WC, 0);

    // Back-to-back loads with a three-cycle response stall on the first.
    issue(1'b0, 1'b0, 18'h010, 32'h0, 32'hDEADBEEF, 1'b0);
    collect("b2b_a", 3, WC, 0);
    issue(1'b0, 1'b0, 18'h030, 32'h0, 32'h11223344, 1'b0);
    collect("b2b_b", 0, WC, 0);

    // Reset in the middle of a store: strobes drop without a clock edge, no response.
    issue(1'b1, 1'b0, 18'h040, 32'h55AA55AA, 32'h0, 1'b0);
    void'(sb_q.pop_front());
    check("mid_pre_strobe", {31'd0, mem_memWrite}, 32'd1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_wr_drop", {31'd0, mem_memWrite}, 32'd0);
    check("mid_rd_low", {31'd0, mem_memRead}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("mid_no_resp", {31'd0, resp_valid}, 32'd0);
    end
    check("mid_ready", {31'd0, req_ready}, 32'd1);
    issue(1'b0, 1'b0, 18'h040, 32'h0, 32'h0, 1'b0);
    collect("post_rst_lw", 0, WC, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
